// File: rtl/pio_fifo_host.sv
// Host-side endpoint for the PIO state machine's TX/RX FIFO pair: valid/ready write and read
// channels, RX flush sequencing and sticky stall flags. Optional counters: PIO_FIFO_HOST_STATS_EN.
module pio_fifo_host #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [WIDTH-1:0]   rd_data,
  input  logic               flush,
  input  logic               clr_flags,
  output logic               tx_push_en,
  output logic [WIDTH-1:0]   tx_data,
  input  logic [COUNT_W-1:0] tx_count,
  output logic               rx_pop_en,
  input  logic [WIDTH-1:0]   rx_data,
  input  logic [COUNT_W-1:0] rx_count,
  output logic               flushing,
  output logic               tx_stall,
  output logic               rx_stall
`ifdef PIO_FIFO_HOST_STATS_EN
  ,
  output logic [15:0]        tx_words,
  output logic [15:0]        rx_words
`endif
);

  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] wbuf_reg;
  logic             wbuf_v_reg;
  logic             rx_nonempty;
  logic             wr_accept;

  assign rx_nonempty = (rx_count != '0);

  // Write side: a single holding register in front of the TX push port.
  assign tx_push_en = wbuf_v_reg && (tx_count < DEPTH_C);
  assign tx_data    = wbuf_reg;
  assign wr_ready   = !rst && (!wbuf_v_reg || tx_push_en);
  assign wr_accept  = wr_valid && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_reg   <= '0;
      wbuf_v_reg <= 1'b0;
    end else if (wr_accept) begin
      wbuf_reg   <= wr_data;
      wbuf_v_reg <= 1'b1;
    end else if (tx_push_en) begin
      wbuf_v_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    rx_pop_en  = 1'b0;
    flushing   = 1'b0;
    case (state_reg)
      IDLE: begin
        rx_pop_en = rx_nonempty && (!rd_valid || rd_ready);
        if (flush) state_next = FLUSH;
      end
      FLUSH: begin
        rx_pop_en = rx_nonempty;
        flushing  = 1'b1;
        if (!rx_nonempty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Output register; a flush request overrides any pop or drain decided in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (state_reg == FLUSH || flush) begin
      rd_valid <= 1'b0;
    end else if (rx_pop_en) begin
      rd_valid <= 1'b1;
      rd_data  <= rx_data;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_stall <= 1'b0;
      rx_stall <= 1'b0;
    end else begin
      if (wr_valid && !wr_ready) tx_stall <= 1'b1;
      else if (clr_flags)        tx_stall <= 1'b0;
      if (rx_count == DEPTH_C)   rx_stall <= 1'b1;
      else if (clr_flags)        rx_stall <= 1'b0;
    end
  end

`ifdef PIO_FIFO_HOST_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_words <= '0;
      rx_words <= '0;
    end else if (clr_flags) begin
      tx_words <= '0;
      rx_words <= '0;
    end else begin
      if (tx_push_en && tx_words != 16'hFFFF)           tx_words <= tx_words + 16'd1;
      if (rd_valid && rd_ready && rx_words != 16'hFFFF) rx_words <= rx_words + 16'd1;
    end
  end
`endif

endmodule
